wb_writer: RTL and testbench

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_writer_pkg.sv | 19 +
 rtl/wb_writer.sv | 115 +++++++++++
 tb/tb_wb_writer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wb_writer_pkg.sv
// Shared processor definitions for the write-back stage: FSM state encoding
// and the hard-wired zero register address.
package wb_writer_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } wb_state_e;

  localparam logic [31:0] ZERO_REG_ADDR = 32'd0;

  // True when a destination address names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [31:0] addr);
    return (addr == ZERO_REG_ADDR);
  endfunction

endpackage

// File: rtl/wb_writer.sv
// Write-back stage: retires ALU results and load returns into the register
// file, stalls upstream while a load is outstanding, and halts on HLT.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic              in_we,
  input  logic              in_ld,
  input  logic              in_hlt,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              mem_vld,
  input  logic [DATA_W-1:0] mem_data,
  output logic              stall,
  output logic              we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst,
  output logic              hlt
);

  wb_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic              hlt_q, hlt_d;
  logic              accept_s;

  assign stall    = (state_q != RUN);
  assign accept_s = in_vld && (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    dst_d      = dst_q;
    dst_addr_d = dst_addr_q;
    ld_addr_d  = ld_addr_q;
    hlt_d      = hlt_q;
    case (state_q)
      RUN: begin
        if (accept_s) begin
          // HLT wins over any write fields carried on the same offer.
          if (in_hlt) begin
            state_d = DRAIN;
          end else if (in_ld) begin
            ld_addr_d = in_addr;
            state_d   = WAIT_MEM;
          end else if (in_we && !is_zero_reg(32'(in_addr))) begin
            we_d       = 1'b1;
            dst_d      = alu_res;
            dst_addr_d = in_addr;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      WAIT_MEM: begin
        if (mem_vld) begin
          state_d = RUN;
          if (!is_zero_reg(32'(ld_addr_q))) begin
            we_d       = 1'b1;
            dst_d      = mem_data;
            dst_addr_d = ld_addr_q;
          end else begin
            we_d = 1'b0;
          end
        end else begin
          state_d = WAIT_MEM;
        end
      end
      DRAIN: begin
        state_d = HALTED;
        hlt_d   = 1'b1;
      end
      HALTED: begin
        state_d = HALTED;
        hlt_d   = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      we_q       <= 1'b0;
      dst_q      <= '0;
      dst_addr_q <= '0;
      ld_addr_q  <= '0;
      hlt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      dst_q      <= dst_d;
      dst_addr_q <= dst_addr_d;
      ld_addr_q  <= ld_addr_d;
      hlt_q      <= hlt_d;
    end
  end

  assign we       = we_q;
  assign dst      = dst_q;
  assign dst_addr = dst_addr_q;
  assign hlt      = hlt_q;

endmodule

// File: tb/tb_wb_writer.sv
// Randomised bench for wb_writer against a transaction-level model of the
// retire/halt rules, preceded by the directed scenarios.
module tb_wb_writer;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_vld = 1'b0, in_we = 1'b0, in_ld = 1'b0, in_hlt = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] alu_res = '0;
  logic          mem_vld = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          stall, we, hlt;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst;

  int n_vec = 0;
  int n_err = 0;

  // Model: idle / waiting-for-load / draining / halted, plus last write.
  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_HALT = 3;
  int            m_mode;
  logic [AW-1:0] m_pend;
  logic          m_we, m_hlt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dst;
  int            halt_steps;

  wb_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_we(in_we), .in_ld(in_ld),
    .in_hlt(in_hlt), .in_addr(in_addr), .alu_res(alu_res), .mem_vld(mem_vld),
    .mem_data(mem_data), .stall(stall), .we(we), .dst_addr(dst_addr),
    .dst(dst), .hlt(hlt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic l, input logic h,
                       input logic [AW-1:0] a, input logic [DW-1:0] r,
                       input logic mv, input logic [DW-1:0] md);
    in_vld = v; in_we = w; in_ld = l; in_hlt = h;
    in_addr = a; alu_res = r; mem_vld = mv; mem_data = md;
  endtask

  task automatic idle(input logic mv, input logic [DW-1:0] md);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, mv, md);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pend = '0; m_we = 1'b0; m_hlt = 1'b0;
    m_addr = '0; m_dst = '0; halt_steps = 0;
  endtask

  // One clock: check stall before the edge, predict, then check after it.
  task automatic step();
    int   nmode;
    logic nwe;
    chk("stall", 32'(stall), 32'(m_mode != M_IDLE));
    nmode = m_mode;
    nwe   = 1'b0;
    if (m_mode == M_IDLE && in_vld) begin
      if (in_hlt) nmode = M_DRAIN;
      else if (in_ld) begin m_pend = in_addr; nmode = M_LOAD; end
      else if (in_we && in_addr != '0) begin nwe = 1'b1; m_dst = alu_res; m_addr = in_addr; end
    end else if (m_mode == M_LOAD && mem_vld) begin
      nmode = M_IDLE;
      if (m_pend != '0) begin nwe = 1'b1; m_dst = mem_data; m_addr = m_pend; end
    end else if (m_mode == M_DRAIN) begin
      nmode = M_HALT;
      m_hlt = 1'b1;
    end
    @(posedge clk);
    #1;
    m_we = nwe;
    m_mode = nmode;
    if (m_mode == M_HALT) halt_steps++;
    chk("we", 32'(we), 32'(m_we));
    chk("dst", 32'(dst), 32'(m_dst));
    chk("dst_addr", 32'(dst_addr), 32'(m_addr));
    chk("hlt", 32'(hlt), 32'(m_hlt));
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear while held.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_dst", 32'(dst), 32'd0);
    chk("rst_addr", 32'(dst_addr), 32'd0);
    chk("rst_hlt", 32'(hlt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    idle(1'b0, '0);
    do_reset();

    // ALU write to R3, then idle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 16'h1234, 1'b0, '0); step();
    chk("alu_we", 32'(we), 32'd1);
    chk("alu_dst", 32'(dst), 32'h1234);
    idle(1'b0, '0); step();
    chk("alu_we_off", 32'(we), 32'd0);

    // R0 write suppressed; spurious mem_vld in RUN ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'hFFFF, 1'b0, '0); step();
    chk("r0_we", 32'(we), 32'd0);
    idle(1'b1, 16'h5555); step();
    chk("spur_we", 32'(we), 32'd0);

    // Load to R5 with three wait cycles.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 16'h0000, 1'b0, '0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 16'h7777, 1'b0, '0); step();
    end
    idle(1'b1, 16'hBEEF); step();
    chk("ld_dst", 32'(dst), 32'hBEEF);
    chk("ld_addr", 32'(dst_addr), 32'd5);
    idle(1'b0, '0); step();

    // Write R2 then HLT; further offers while halted.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 16'h00A5, 1'b0, '0); step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 16'h0BAD, 1'b0, '0); step();
    chk("hlt_r2", 32'(dst_addr), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(1, 15)),
            16'($urandom), 1'b1, 16'($urandom));
      step();
    end
    chk("halted", 32'(hlt), 32'd1);
    do_reset();

    // Reset in WAIT_MEM, then a late mem_vld.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, '0, 1'b0, '0); step();
    idle(1'b0, '0); step();
    do_reset();
    idle(1'b1, 16'hCAFE); step();
    chk("rstld_we", 32'(we), 32'd0);
    chk("rstld_stall", 32'(stall), 32'd0);

    // Reset in DRAIN abandons the halt.
    drive(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, '0); step();
    do_reset();
    idle(1'b0, '0); step(); step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
            4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 9) < 4), 16'($urandom));
      step();
      if (halt_steps > 8 || $urandom_range(0, 149) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
